act_requant: RTL
================

ACT_REQUANT -- requirements
Module: act_requant

Interface
REQ-001 Parameter IN_W, default 18, signed neuron-output width.
REQ-002 Parameter OUT_W, default 8, signed activation width, matching the neuron x input.
REQ-003 Parameter DEPTH, default 4, output FIFO entries, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_y and in_shift are valid this cycle.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 in_y  input  IN_W  signed neuron output y.
REQ-009 in_shift  input  4  right-shift amount, 0..15, sampled with in_y.
REQ-010 out_valid  output  1  out_x holds the FIFO head.
REQ-011 out_ready  input  1  consumer takes the head this cycle.
REQ-012 out_x  output  OUT_W  signed requantized activation.
REQ-013 sat_pulse  output  1  one-cycle pulse when a saturated value is written to the FIFO.
REQ-014 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Accept occurs on a rising edge where in_valid and in_ready are both high; otherwise inputs are ignored.
REQ-016 Stage 1 registers r = (in_y + round) >>> in_shift in IN_W+1 bits.
REQ-017 round is 0 when in_shift = 0, else 1 << (in_shift-1): round-half-up, arithmetic shift.
REQ-018 Stage 2 saturates r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (-128..127 at the defaults), writes the result to the FIFO, and raises sat_pulse for that cycle when clamping occurred.
REQ-019 Latency: a sample accepted at edge k is visible on out_x/out_valid after edge k+2 if the FIFO was empty.
REQ-020 Stages never stall; flow control is credit-based.
REQ-021 in_ready = (level + stage1_valid + stage2_valid) < DEPTH, combinational from registered state only.
REQ-022 Pop occurs on a rising edge where out_valid and out_ready are both high.
REQ-023 out_x is the head entry.
REQ-024 out_x stays stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop leaves level unchanged and is legal when full or empty (empty: push-through with no bypass; the entry appears the next cycle).
REQ-026 FIFO pointers wrap modulo DEPTH.
REQ-027 Overflow and underflow are impossible by construction.
REQ-028 Samples leave in acceptance order; there is no loss or duplication.

Reset
REQ-029 Asserting rst_n low at any time, including mid-transfer, immediately clears both stage-valid bits, the FIFO pointers and level.
REQ-030 During reset: out_valid=0, sat_pulse=0, level=0, out_x=0, in_ready=0.
REQ-031 in_ready rises on the first edge after deassertion.
REQ-032 In-flight samples are discarded by reset and never appear on out_x.

Structure
REQ-033 Shared package act_pkg holds the width constants IN_W/OUT_W defaults, the saturation limits ACT_MAX/ACT_MIN, and the shift-width constant.
REQ-034 The FIFO is the sub-module act_fifo (storage, pointers, level).
REQ-035 Rounding, saturation and credit logic stay in act_requant.

Verification
REQ-036 Passthrough: y=7, shift=0 -> out_x=7; y=95, shift=0 -> out_x=95; sat_pulse=0; each appears two edges after accept.
REQ-037 Rounding: y=5, shift=1 -> 3; y=-21, shift=2 -> -5; y=20, shift=3 -> 3.
REQ-038 Saturation: y=300, shift=1 -> 127 with a single sat_pulse; y=-200, shift=0 -> -128 with sat_pulse; y=131071, shift=15 -> 4 with no pulse.
REQ-039 Backpressure: out_ready=0 with in_valid held high for 8 cycles -> exactly 4 accepts, then in_ready=0 and level=4; out_ready=1 -> values drain in order, and each pop restores one credit.
REQ-040 Full-concurrency: level=4 with out_ready=1 and in_valid=1 continuously -> one accept and one pop per cycle in steady state, level steady, no data lost.
REQ-041 Mid-flight reset: pulse rst_n low one cycle after an accept with level=2 -> out_valid=0, level=0, and the discarded sample never appears after release.

Source files
------------

// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg
// Shared constants for the activation requantizer:
//   IN_W_DEF / OUT_W_DEF : default neuron-output and activation widths
//   SHIFT_W              : width of the per-sample right-shift amount
//   ACT_MAX / ACT_MIN    : saturation limits of a default-width activation
//   act_max() / act_min(): the same limits for an arbitrary signed width
// -----------------------------------------------------------------------------
package act_pkg;

    localparam int IN_W_DEF  = 18;
    localparam int OUT_W_DEF = 8;
    localparam int SHIFT_W   = 4;

    function automatic int act_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int act_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int ACT_MAX = act_max(OUT_W_DEF);
    localparam int ACT_MIN = act_min(OUT_W_DEF);

endpackage

// File: rtl/act_requant_if.sv
// -----------------------------------------------------------------------------
// act_requant_if
// Handshake bundle of the requantizer.
//   Input stream : in_valid, in_ready, in_y (signed IN_W), in_shift (0..15)
//   Output stream: out_valid, out_ready, out_x (signed OUT_W)
//   Status       : sat_pulse (clamped value written), level (FIFO occupancy)
// Modports: slave = the requantizer, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface act_requant_if import act_pkg::*; #(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_y;
    logic [SHIFT_W-1:0]      in_shift;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_x;
    logic                    sat_pulse;
    logic [LW-1:0]           level;

    modport slave (
        input  in_valid, in_y, in_shift, out_ready,
        output in_ready, out_valid, out_x, sat_pulse, level
    );

    modport master (
        output in_valid, in_y, in_shift, out_ready,
        input  in_ready, out_valid, out_x, sat_pulse, level
    );
endinterface

// File: rtl/act_fifo.sv
// -----------------------------------------------------------------------------
// act_fifo
// Output FIFO of the requantizer (DEPTH a power of two, >= 2).
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/level only)
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head (caller only pops when valid_o)
//   rd_data_o    : head entry, forced to zero while empty
//   valid_o      : FIFO not empty
//   level_o      : occupancy 0..DEPTH
// The caller guarantees no overflow, so push and pop are never qualified.
// -----------------------------------------------------------------------------
module act_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   level_q;
    logic [PW:0]   level_d;

    // Storage carries no reset; stale contents are never visible because the
    // head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign valid_o   = (level_q != '0);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;

endmodule

// File: rtl/act_requant.sv
// -----------------------------------------------------------------------------
// act_requant
// Requantizes a signed neuron output to a signed activation:
//   stage 1: r = (y + round) >>> shift, round-half-up, IN_W+1 bits
//   stage 2: saturate r to OUT_W bits, flag clamping
//   then   : write into act_fifo, drained by the output handshake
// Ports: clk, rst_n (asynchronous, active-low), bus (act_requant_if.slave).
// Stages never stall; in_ready is a credit check that counts FIFO entries plus
// samples still in flight, so the FIFO can never overflow.
// -----------------------------------------------------------------------------
module act_requant import act_pkg::*; #(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    act_requant_if.slave  bus
);
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int SAT_MAX = (OUT_W == OUT_W_DEF) ? ACT_MAX : act_max(OUT_W);
    localparam int SAT_MIN = (OUT_W == OUT_W_DEF) ? ACT_MIN : act_min(OUT_W);
    localparam logic signed [IN_W:0] R_MAX = (IN_W + 1)'(SAT_MAX);
    localparam logic signed [IN_W:0] R_MIN = (IN_W + 1)'(SAT_MIN);

    // Holds in_ready low during reset and releases it on the first edge after.
    logic                    ready_en_q;
    logic                    s1_valid_q;
    logic signed [IN_W:0]    s1_r_q;
    logic signed [IN_W:0]    s1_r_d;
    logic signed [IN_W:0]    round_d;
    logic signed [IN_W:0]    sum_d;
    logic                    s2_valid_q;
    logic                    s2_sat_q;
    logic                    s2_sat_d;
    logic signed [OUT_W-1:0] s2_x_q;
    logic signed [OUT_W-1:0] s2_x_d;

    logic [LW-1:0]           level;
    logic [LW:0]             committed;
    logic                    in_ready;
    logic                    accept;
    logic                    pop;
    logic                    fifo_valid;
    logic [OUT_W-1:0]        fifo_data;

    assign committed = {1'b0, level} + (LW + 1)'(s1_valid_q) + (LW + 1)'(s2_valid_q);
    assign in_ready  = ready_en_q && (committed < (LW + 1)'(DEPTH));
    assign accept    = bus.in_valid && in_ready;
    assign pop       = fifo_valid && bus.out_ready;

    // Rounding: one extra bit absorbs y + round without overflow.
    always_comb begin
        round_d = '0;
        if (bus.in_shift != '0) begin
            round_d = (IN_W + 1)'(1) << (bus.in_shift - SHIFT_W'(1));
        end
        sum_d  = $signed({bus.in_y[IN_W-1], bus.in_y}) + round_d;
        s1_r_d = sum_d >>> bus.in_shift;
    end

    // Saturation of the stage-1 result.
    always_comb begin
        s2_sat_d = 1'b0;
        s2_x_d   = s1_r_q[OUT_W-1:0];
        if (s1_r_q > R_MAX) begin
            s2_sat_d = 1'b1;
            s2_x_d   = R_MAX[OUT_W-1:0];
        end else if (s1_r_q < R_MIN) begin
            s2_sat_d = 1'b1;
            s2_x_d   = R_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_x_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= accept;
            if (accept) s1_r_q <= s1_r_d;
            s2_valid_q <= s1_valid_q;
            s2_sat_q   <= s1_valid_q && s2_sat_d;
            if (s1_valid_q) s2_x_q <= s2_x_d;
        end
    end

    act_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s2_valid_q),
        .push_data_i (s2_x_q),
        .pop_i       (pop),
        .rd_data_o   (fifo_data),
        .valid_o     (fifo_valid),
        .level_o     (level)
    );

    // Stage 2 writes the FIFO in the cycle it holds a sample, so the pulse
    // coincides with the write.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = fifo_valid;
    assign bus.out_x     = fifo_data;
    assign bus.sat_pulse = s2_valid_q && s2_sat_q;
    assign bus.level     = level;

endmodule
